// File: rtl/mag_cmp_pkg.sv
// mag_cmp_pkg: shared types, result encodings and tree sizing helper for the
// mag_cmp unsigned magnitude comparator.
package mag_cmp_pkg;

  // One comparison result: g = "greater than", l = "less than".
  typedef struct packed {
    logic g;
    logic l;
  } cmp_t;

  localparam cmp_t CMP_EQ = 2'b00;
  localparam cmp_t CMP_LT = 2'b01;
  localparam cmp_t CMP_GT = 2'b10;

  // Number of tree levels needed so that split**depth >= width.
  // max_depth bounds the loop; ceil(log2(width)) is always enough for split >= 2.
  function automatic int tree_depth(input int width, input int split,
                                    input int max_depth);
    int depth;
    int span;
    depth = 0;
    span  = 1;
    for (int i = 0; i < max_depth; i++) begin
      if (span < width) begin
        span  = span * split;
        depth = depth + 1;
      end
    end
    return depth;
  endfunction

endpackage

// File: rtl/mag_cmp_node.sv
// mag_cmp_node: combinational tree node. Merges SPLIT child results ordered
// LSB..MSB; the most-significant child that is not "equal" decides.
module mag_cmp_node
  import mag_cmp_pkg::*;
#(
  parameter int SPLIT = 2
) (
  input  cmp_t kids_i [SPLIT],
  output cmp_t res_o
);

  // Walk LSB to MSB so a later (more significant) unequal child overrides.
  always_comb begin
    res_o = CMP_EQ;
    for (int i = 0; i < SPLIT; i++) begin
      if (kids_i[i] != CMP_EQ) begin
        res_o = kids_i[i];
      end
    end
  end

endmodule

// File: rtl/mag_cmp.sv
// mag_cmp: parameterizable unsigned magnitude comparator (val vs rfr).
// Bit leaves feed a SPLIT-ary combinational tree; the root result is
// registered once together with the valid qualifier.
// Optional MAG_CMP_EQU_EN adds a registered equality output `equ`.
module mag_cmp
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] rfr,
  output logic             vld_o,
  output logic             grt,
  output logic             lst
`ifdef MAG_CMP_EQU_EN
  ,
  output logic             equ
`endif
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int DEPTH     = tree_depth(WIDTH, SPLIT, WIDTH_LOG);
  // Power-of-two radix reduces to a shift; other radices use the power.
  localparam int PAD_W     = (SPLIT == (1 << SPLIT_LOG)) ? (1 << (SPLIT_LOG * DEPTH))
                                                         : SPLIT ** DEPTH;

  genvar gi, gj, gk;

  // Leaves: one per padded bit position. Bits above WIDTH are implicit zeros
  // on both operands, so they always compare equal.
  cmp_t leaf [PAD_W];

  for (gi = 0; gi < PAD_W; gi++) begin : g_leaf
    if (gi < WIDTH) begin : g_real
      assign leaf[gi].g = val[gi] & ~rfr[gi];
      assign leaf[gi].l = ~val[gi] & rfr[gi];
    end else begin : g_pad
      assign leaf[gi] = CMP_EQ;
    end
  end

  // Tree levels: level gi reduces PAD_W/SPLIT**gi results to PAD_W/SPLIT**(gi+1).
  for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
    localparam int N_OUT = PAD_W / (SPLIT ** (gi + 1));
    cmp_t res [N_OUT];

    for (gj = 0; gj < N_OUT; gj++) begin : g_node
      cmp_t kids [SPLIT];

      for (gk = 0; gk < SPLIT; gk++) begin : g_kid
        if (gi == 0) begin : g_from_leaf
          assign kids[gk] = leaf[gj * SPLIT + gk];
        end else begin : g_from_lvl
          assign kids[gk] = g_lvl[gi - 1].res[gj * SPLIT + gk];
        end
      end

      mag_cmp_node #(
        .SPLIT (SPLIT)
      ) u_node (
        .kids_i (kids),
        .res_o  (res[gj])
      );
    end
  end

  cmp_t root;

  if (DEPTH == 0) begin : g_root_leaf
    assign root = leaf[0];
  end else begin : g_root_tree
    assign root = g_lvl[DEPTH - 1].res[0];
  end

  logic vld_q, vld_d;
  cmp_t res_q, res_d;

  assign vld_d = vld_i;
  assign res_d = root;

  // Output stage: qualifier and result register every cycle, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= CMP_EQ;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

  assign vld_o = vld_q;
  assign grt   = res_q.g;
  assign lst   = res_q.l;

`ifdef MAG_CMP_EQU_EN
  logic equ_q, equ_d;

  assign equ_d = ~(root.g | root.l);

  // Equality flag registered alongside grt/lst from the same sampled operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      equ_q <= 1'b0;
    end else begin
      equ_q <= equ_d;
    end
  end

  assign equ = equ_q;
`endif

endmodule

// File: tb/tb_mag_cmp.sv
// tb_mag_cmp: directed self-checking bench for mag_cmp (main 4/2 instance plus
// padding / degenerate configurations).
module tb_mag_cmp;

  logic       clk;
  logic       rst_n;
  logic       vld_i;
  logic [3:0] val, rfr;
  logic       vld_o, grt, lst;
`ifdef MAG_CMP_EQU_EN
  logic       equ;
`endif

  logic [4:0] val5, rfr5;
  logic       vld5, grt5, lst5;
  logic [2:0] val3, rfr3;
  logic       vld3, grt3, lst3;
  logic [0:0] val1, rfr1;
  logic       vld1, grt1, lst1;
`ifdef MAG_CMP_EQU_EN
  logic       equ5, equ3, equ1;
`endif

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mag_cmp #(.WIDTH(4), .SPLIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .val(val), .rfr(rfr),
    .vld_o(vld_o), .grt(grt), .lst(lst)
`ifdef MAG_CMP_EQU_EN
    , .equ(equ)
`endif
  );

  mag_cmp #(.WIDTH(5), .SPLIT(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .vld_i(1'b1), .val(val5), .rfr(rfr5),
    .vld_o(vld5), .grt(grt5), .lst(lst5)
`ifdef MAG_CMP_EQU_EN
    , .equ(equ5)
`endif
  );

  mag_cmp #(.WIDTH(3), .SPLIT(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .vld_i(1'b1), .val(val3), .rfr(rfr3),
    .vld_o(vld3), .grt(grt3), .lst(lst3)
`ifdef MAG_CMP_EQU_EN
    , .equ(equ3)
`endif
  );

  mag_cmp #(.WIDTH(1), .SPLIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .vld_i(1'b1), .val(val1), .rfr(rfr1),
    .vld_o(vld1), .grt(grt1), .lst(lst1)
`ifdef MAG_CMP_EQU_EN
    , .equ(equ1)
`endif
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive main operands at the falling edge, then sample 1 time unit after
  // the next rising edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    vld_i = v;
    val   = a;
    rfr   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic ev, input logic eg,
                            input logic el);
    check({tag, ".vld"}, vld_o, ev);
    check({tag, ".grt"}, grt, eg);
    check({tag, ".lst"}, lst, el);
`ifdef MAG_CMP_EQU_EN
    check({tag, ".equ"}, equ, ev & ~eg & ~el);
`endif
    $display("txn %-10s vld_i=%b val=%h rfr=%h -> vld_o=%b grt=%b lst=%b",
             tag, vld_i, val, rfr, vld_o, grt, lst);
  endtask

  // Hand-computed vectors: {val, rfr, grt, lst}
  logic [9:0] eq_vec [8];
  logic [9:0] ne_vec [8];

  initial begin
    eq_vec[0] = {4'hA, 4'hA, 2'b00};
    eq_vec[1] = {4'h0, 4'h0, 2'b00};
    eq_vec[2] = {4'hF, 4'hF, 2'b00};
    eq_vec[3] = {4'h3, 4'h3, 2'b00};
    eq_vec[4] = {4'h5, 4'h5, 2'b00};
    eq_vec[5] = {4'hC, 4'hC, 2'b00};
    eq_vec[6] = {4'h1, 4'h1, 2'b00};
    eq_vec[7] = {4'h7, 4'h7, 2'b00};
    ne_vec[0] = {4'h9, 4'h6, 2'b10};
    ne_vec[1] = {4'h7, 4'h8, 2'b01};
    ne_vec[2] = {4'h4, 4'h5, 2'b01};
    ne_vec[3] = {4'hF, 4'h0, 2'b10};
    ne_vec[4] = {4'h0, 4'hF, 2'b01};
    ne_vec[5] = {4'hB, 4'hA, 2'b10};
    ne_vec[6] = {4'h2, 4'hC, 2'b01};
    ne_vec[7] = {4'hE, 4'hD, 2'b10};

    rst_n = 1'b0;
    vld_i = 1'b0;
    val = 4'h0; rfr = 4'h0;
    val5 = 5'h0; rfr5 = 5'h0;
    val3 = 3'h0; rfr3 = 3'h0;
    val1 = 1'b0; rfr1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_main("reset", 1'b0, 1'b0, 1'b0);

    // Zero operands
    step(1'b1, 4'h0, 4'h0);
    check_main("zero", 1'b1, 1'b0, 1'b0);

    // Equal pairs, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, eq_vec[i][9:6], eq_vec[i][5:2]);
      check_main("equal", 1'b1, eq_vec[i][1], eq_vec[i][0]);
    end

    // Unequal pairs, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, ne_vec[i][9:6], ne_vec[i][5:2]);
      check_main("notequal", 1'b1, ne_vec[i][1], ne_vec[i][0]);
    end

    // Asynchronous reset mid-cycle with vld_o=1, grt=1
    step(1'b1, 4'h9, 4'h6);
    check_main("pre_rst", 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_main("rst_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_main("rst_rel", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_main("rst_edge", 1'b1, 1'b1, 1'b0);

    // Valid pipeline 1,0,1,1 with X operands while invalid
    step(1'b1, 4'h3, 4'h2);
    check_main("vld_a", 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'hx, 4'hx);
    check("vld_b.vld", vld_o, 1'b0);
    $display("txn vld_b      vld_i=0 val=x rfr=x -> vld_o=%b", vld_o);
    step(1'b1, 4'h2, 4'h3);
    check_main("vld_c", 1'b1, 1'b0, 1'b1);
    step(1'b1, 4'h6, 4'h6);
    check_main("vld_d", 1'b1, 1'b0, 1'b0);

    // Padding / degenerate configurations
    @(negedge clk);
    val5 = 5'h10; rfr5 = 5'h0F;
    val3 = 3'h3;  rfr3 = 3'h3;
    val1 = 1'b1;  rfr1 = 1'b0;
    @(posedge clk);
    #1;
    check("w5_gt.vld", vld5, 1'b1);
    check("w5_gt.grt", grt5, 1'b1);
    check("w5_gt.lst", lst5, 1'b0);
    check("w3_eq.grt", grt3, 1'b0);
    check("w3_eq.lst", lst3, 1'b0);
    check("w1_gt.grt", grt1, 1'b1);
    check("w1_gt.lst", lst1, 1'b0);
    $display("txn pad_a      w5 10>0F grt=%b lst=%b | w3 3=3 grt=%b lst=%b | w1 1>0 grt=%b lst=%b",
             grt5, lst5, grt3, lst3, grt1, lst1);

    @(negedge clk);
    val5 = 5'h0F; rfr5 = 5'h10;
    val3 = 3'h4;  rfr3 = 3'h3;
    val1 = 1'b0;  rfr1 = 1'b1;
    @(posedge clk);
    #1;
    check("w5_lt.grt", grt5, 1'b0);
    check("w5_lt.lst", lst5, 1'b1);
    check("w3_gt.grt", grt3, 1'b1);
    check("w3_gt.lst", lst3, 1'b0);
    check("w1_lt.grt", grt1, 1'b0);
    check("w1_lt.lst", lst1, 1'b1);
    $display("txn pad_b      w5 0F<10 grt=%b lst=%b | w3 4>3 grt=%b lst=%b | w1 0<1 grt=%b lst=%b",
             grt5, lst5, grt3, lst3, grt1, lst1);

    @(negedge clk);
    val3 = 3'h2;  rfr3 = 3'h5;
    val5 = 5'h11; rfr5 = 5'h11;
    @(posedge clk);
    #1;
    check("w3_lt.grt", grt3, 1'b0);
    check("w3_lt.lst", lst3, 1'b1);
    check("w5_eq.grt", grt5, 1'b0);
    check("w5_eq.lst", lst5, 1'b0);
    $display("txn pad_c      w3 2<5 grt=%b lst=%b | w5 11=11 grt=%b lst=%b",
             grt3, lst3, grt5, lst5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
